mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit owning the architectural HI/LO registers.

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, with a start/busy/done handshake.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, b_reg;
  logic             is_div, neg_lo, neg_hi, dz_flag;

  logic             accept, arith_op, is_signed, rs_neg, rt_neg, rt_zero, op_div;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept    = start && (state == IDLE || state == DONE);
  assign arith_op  = (op[2] == 1'b0);
  assign op_div    = op[1];
  assign is_signed = (op[0] == 1'b0);
  assign rs_neg    = is_signed && rs_val[WIDTH-1];
  assign rt_neg    = is_signed && rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? -rs_val : rs_val;
  assign rt_abs    = rt_neg ? -rt_val : rt_val;
  assign rt_zero   = (rt_val == '0);

  // Multiply keeps the partial product in {acc_hi, acc_lo}; divide keeps remainder/quotient there.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_lo ? -prod : prod;
  assign quo_fix  = dz_flag ? '1 : (neg_lo ? -acc_lo : acc_lo);
  assign rem_fix  = neg_hi ? -acc_hi : acc_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = (accept && arith_op) ? CALC : IDLE;
      CALC: begin
        if (flush)                            next_state = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))    next_state = FIX;
      end
      FIX:     next_state = flush ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == CALC) || (state == FIX);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && dz_flag;
  end

  // A zero divisor keeps the raw dividend so it shifts out unchanged into the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      b_reg   <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz_flag <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      if (arith_op) begin
        cnt     <= '0;
        acc_hi  <= '0;
        is_div  <= op_div;
        dz_flag <= op_div && rt_zero;
        if (op_div) begin
          acc_lo <= rt_zero ? rs_val : rs_abs;
          b_reg  <= rt_abs;
          neg_lo <= !rt_zero && (rs_neg ^ rt_neg);
          neg_hi <= !rt_zero && rs_neg;
        end else begin
          acc_lo <= rt_abs;
          b_reg  <= rs_abs;
          neg_lo <= rs_neg ^ rt_neg;
          neg_hi <= 1'b0;
        end
      end else if (op == 3'b100) begin
        hi <= rs_val;
      end else if (op == 3'b101) begin
        lo <= rs_val;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end else if (state == FIX && !flush) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_hi, cur_lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Reference: signed/unsigned 64-bit arithmetic, with the divide-by-zero rule handled explicitly.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    mdz = 1'b0;
    mh = '0;
    ml = '0;
    case (o)
      3'd0: begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; mh = p[63:32]; ml = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          mh = a; ml = 32'hFFFF_FFFF; mdz = 1'b1;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb; ml = sq[31:0]; mh = sr[31:0];
        end else begin
          ml = a / b; mh = a % b;
        end
      end
    endcase
  endfunction

  // Issues one op from just after a negedge and waits (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic fl,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rdz,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    rh = hi; rl = lo; rdz = div_by_zero;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got busy=%b done=%b dz=%b want 000", busy, done, div_by_zero);
    end
    rst = 1'b0;
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [2:0]  t_op [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
    logic [31:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd10, 32'hFFFFFFFB};
    logic [31:0] t_b  [7] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h0000000A, 32'hFFFFFFFB};
    logic [31:0] t_lo [7] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        t_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] rh, rl;
    logic        rdz;
    int          lat, bcnt;
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, rh, rl, rdz, lat, bcnt);
      total++;
      if (lat !== 33) begin bad++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
      total++;
      if (bcnt !== 33) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bcnt); end
      total++;
      if (rh !== t_hi[i] || rl !== t_lo[i]) begin
        bad++; $display("FAIL dir%0d_result: got hi=%h lo=%h want hi=%h lo=%h", i, rh, rl, t_hi[i], t_lo[i]);
      end
      total++;
      if (rdz !== t_dz[i]) begin bad++; $display("FAIL dir%0d_dz: got %b want %b", i, rdz, t_dz[i]); end
      cur_hi = t_hi[i]; cur_lo = t_lo[i];
      @(negedge clk);
      total++;
      if (done !== 1'b0 || div_by_zero !== 1'b0) begin
        bad++; $display("FAIL dir%0d_pulse: got done=%b dz=%b want 0 0", i, done, div_by_zero);
      end
    end
  endtask

  task automatic test_mt_ops;
    start = 1'b1; op = 3'd4; rs_val = 32'hCAFE0001;
    @(negedge clk);
    start = 1'b0;
    cur_hi = 32'hCAFE0001;
    total++;
    if (hi !== cur_hi || lo !== cur_lo || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h 0 0", hi, lo, busy, done, cur_hi, cur_lo);
    end
    start = 1'b1; op = 3'd5; rs_val = 32'h0BAD0002;
    @(negedge clk);
    cur_lo = 32'h0BAD0002;
    op = 3'd6; rs_val = 32'h11111111;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (hi !== cur_hi || lo !== cur_lo || busy !== 1'b0) begin
      bad++; $display("FAIL mtlo_noop: got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", hi, lo, busy, cur_hi, cur_lo);
    end
  endtask

  task automatic test_flush;
    bit saw;
    start = 1'b1; op = 3'd0; rs_val = 32'h00001234; rt_val = 32'h00005678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== cur_hi || lo !== cur_lo) begin
      bad++; $display("FAIL flush_abort: got busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, cur_hi, cur_lo);
    end
    saw = 0;
    repeat (40) begin @(negedge clk); if (done) saw = 1; end
    total++;
    if (saw) begin bad++; $display("FAIL flush_no_done: got done pulse want none"); end
    start = 1'b1; op = 3'd4; rs_val = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    cur_hi = 32'h00001234;
    total++;
    if (hi !== cur_hi) begin bad++; $display("FAIL flush_mthi: got %h want %h", hi, cur_hi); end
    // flush together with a start while busy: abort, the start is dropped
    start = 1'b1; op = 3'd3; rs_val = 32'd5000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd1; rs_val = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    saw = busy;
    repeat (40) begin @(negedge clk); if (done || busy) saw = 1; end
    total++;
    if (saw || hi !== cur_hi || lo !== cur_lo) begin
      bad++; $display("FAIL flush_start_busy: got activity=%b hi=%h lo=%h want 0 %h %h", saw, hi, lo, cur_hi, cur_lo);
    end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] eh, el;
    logic        edz;
    int          lat;
    model(3'd1, 32'h12345678, 32'h9ABCDEF0, eh, el, edz);
    start = 1'b1; op = 3'd1; rs_val = 32'h12345678; rt_val = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b1; op = 3'd0; rs_val = 32'hDEADBEEF; rt_val = 32'h00000077;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
    total++;
    if (hi !== eh || lo !== el) begin
      bad++; $display("FAIL busy_start_result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, eh, el);
    end
    cur_hi = eh; cur_lo = el;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rh, rl, eh, el;
    logic        rdz, edz;
    int          lat, bcnt;
    run_op(3'd2, 32'hFFFF0000, 32'h00000123, 1'b0, rh, rl, rdz, lat, bcnt);
    run_op(3'd0, 32'h7FFFFFFF, 32'h80000000, 1'b0, rh, rl, rdz, lat, bcnt);
    model(3'd0, 32'h7FFFFFFF, 32'h80000000, eh, el, edz);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    total++;
    if (rh !== eh || rl !== el) begin
      bad++; $display("FAIL b2b_result: got hi=%h lo=%h want hi=%h lo=%h", rh, rl, eh, el);
    end
    cur_hi = eh; cur_lo = el;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush_idle;
    logic [31:0] rh, rl;
    logic        rdz;
    int          lat, bcnt;
    run_op(3'd3, 32'd1000, 32'd9, 1'b1, rh, rl, rdz, lat, bcnt);
    total++;
    if (lat !== 33 || rh !== 32'd1 || rl !== 32'd111) begin
      bad++; $display("FAIL flush_idle: got lat=%0d hi=%h lo=%h want 33 1 6f", lat, rh, rl);
    end
    cur_hi = 32'd1; cur_lo = 32'd111;
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b, rh, rl, eh, el;
    logic        rdz, edz;
    int          lat, bcnt, sel;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) a = 32'h80000000;
      if (sel == 2) b = 32'hFFFFFFFF;
      if (sel == 3) b = {28'd0, b[3:0]};
      model(o, a, b, eh, el, edz);
      run_op(o, a, b, 1'b0, rh, rl, rdz, lat, bcnt);
      total++;
      if (lat !== 33 || rh !== eh || rl !== el || rdz !== edz) begin
        bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b want 33 %h %h %b",
                 i, o, a, b, lat, rh, rl, rdz, eh, el, edz);
      end
      cur_hi = eh; cur_lo = el;
    end
  endtask

  task automatic test_reset_mid;
    bit saw;
    start = 1'b1; op = 3'd2; rs_val = 32'hFFFFE19F; rt_val = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (40) begin @(negedge clk); if (done || busy) saw = 1; end
    total++;
    if (saw) begin bad++; $display("FAIL reset_mid_quiet: got activity after reset want none"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_ops();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_flush_idle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
